mux_select_arbiter: RTL and testbench
=====================================

Name: mux_select_arbiter

Overview:
- Round-robin arbiter that shares the 10-input selection mux (10:1, 4-bit select) among ten requesters.
- Each requester raises a request. The arbiter grants one at a time and drives the mux select with the granted index.
- The granted requester's data therefore appears on the mux output X.
- A per-grant hold limit prevents any one requester from starving the others.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one grant may last (legal range 1..255).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  10  request vector; bit i = requester i wants the mux
- grant  output  10  one-hot grant; all zero when idle
- select  output  4  mux select, index of current/last grant (0..9 only)
- valid  output  1  high while a grant is active; X is meaningful only then
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
  - Clock is clk, reset is rst_n.
  - All state is cleared immediately on rst_n low, without waiting for a clock edge.
- Reset values: grant=0, select=0, valid=0, timeout=0, state=IDLE, hold_cnt=0, ptr=9.
  - ptr=9 means the first search after reset starts at index 0.
- All outputs are registered. There is no combinational path from req to any output.
- Search rule:
  - Search order is ptr+1, ptr+2, … up to ptr+10, taken mod 10.
  - The first index whose req bit is high wins.
  - The previous owner therefore has the lowest priority.
- States:
  - IDLE: at each edge, if any req is high, pick a winner by the search rule and enter GRANT.
    - On entering GRANT: grant[w]=1, select=w, valid=1, ptr=w, hold_cnt=0.
    - Latency: req sampled at edge n gives grant visible after edge n.
    - If no req is high, stay in IDLE: grant=0, valid=0, select holds its last value.
  - GRANT, release by requester: at each edge, if req[select]=0, the grant ends.
  - GRANT, release by limit: if hold_cnt = MAX_HOLD-1, the grant ends and timeout pulses high for one cycle.
  - GRANT, otherwise: hold_cnt increments and the grant is unchanged.
  - On grant end: search again, in the same edge, from ptr+1.
    - If a winner exists, the new grant takes effect immediately (back-to-back, no idle gap).
    - Otherwise go to IDLE.
- Boundary conditions:
  - Timeout while the owner is the sole requester: the search wraps to the owner itself. It is re-granted with hold_cnt=0 and timeout still pulses.
  - Timeout while others request: the next index in the search order is granted; the former owner goes to the back of the order.
  - Owner drops req in the same edge the limit is reached: treat as a normal release; timeout=0.
  - Wrap-around: with ptr=9, index 0 has the highest priority.
  - select never takes 10..15.
  - Requests for non-owners may change freely mid-grant; they have no effect until the next search.
  - MAX_HOLD=1: every grant lasts exactly one cycle. Continuous requesters rotate every cycle.
  - Reset mid-grant: outputs go to reset values immediately; the first search after rst_n deasserts starts at index 0.
- Width rule: hold_cnt is 8 bits and compares against MAX_HOLD-1. ptr and select are 4 bits and wrap 9→0 explicitly, not by modulo-16 overflow.

Test Plan:
- Reset, then req=10'b0000001000 at cycle 2 → after the next edge grant=0x008, select=3, valid=1. Drop req[3] → next edge grant=0, valid=0, select stays 3.
- req=0x3FF held constantly, MAX_HOLD=8 → grants rotate 0,1,…,9,0, each lasting 8 cycles, with back-to-back changes. Each change coincides with a 1-cycle timeout pulse.
- Only req[9] high, held for 20 cycles, MAX_HOLD=8 → grant stays 0x200 throughout, timeout pulses at cycles 8 and 16, valid stays 1.
- Owner 2 with req[2] and req[5] high; req[2] drops at the edge where hold_cnt=7 → select=5 after that edge, timeout=0.
- ptr=9, then req[0] and req[8] both rise → grant=0x001 first; release → grant=0x100. Verify the bench mux X matches d0, then d8.
- rst_n pulled low mid-grant, between clock edges → grant, valid and select are 0 with no clock edge needed. After release with req=0x3FF, index 0 is granted first.

Source files
------------

// File: rtl/mux_select_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_select_arbiter
// Purpose  : Round-robin arbiter that shares a 10:1 selection mux among ten
//            requesters. One requester is granted at a time, and the granted
//            index drives the mux select. A per-grant hold limit (MAX_HOLD)
//            stops any single owner from starving the others.
// Ports    : clk        - system clock, rising edge
//            rst_n      - asynchronous active-low reset
//            req_i      - request vector, bit i = requester i wants the mux
//            grant_o    - one-hot grant, all zero when idle
//            select_o   - mux select, index of current/last grant (0..9)
//            valid_o    - high while a grant is active
//            timeout_o  - one-cycle pulse when the hold limit revokes a grant
// Revision : 1.0 - initial release
// ============================================================================
module mux_select_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] req_i,
    output logic [9:0] grant_o,
    output logic [3:0] select_o,
    output logic       valid_o,
    output logic       timeout_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [7:0] C_HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q,   state_d;
    logic [9:0] grant_q,   grant_d;
    logic [3:0] select_q,  select_d;
    logic       valid_q,   valid_d;
    logic       timeout_q, timeout_d;
    logic [7:0] hold_q,    hold_d;
    logic [3:0] ptr_q,     ptr_d;

    logic       found_w;
    logic [3:0] win_w;
    logic       owner_req_w;

    // Round-robin search starting just after ptr_q. The first loop covers
    // indices above the pointer, the second wraps to 0..ptr_q, so the
    // previous owner is checked last.
    always_comb begin
        found_w = 1'b0;
        win_w   = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (!found_w && req_i[i] && (4'(i) > ptr_q)) begin
                found_w = 1'b1;
                win_w   = 4'(i);
            end
        end
        for (int i = 0; i < 10; i++) begin
            if (!found_w && req_i[i] && (4'(i) <= ptr_q)) begin
                found_w = 1'b1;
                win_w   = 4'(i);
            end
        end
    end

    // grant_q is one-hot while granting, so masking avoids indexing req_i
    // with the 4-bit select.
    assign owner_req_w = |(req_i & grant_q);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        select_d  = select_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        hold_d    = hold_q;
        ptr_d     = ptr_q;

        if ((state_q == ST_IDLE) || !owner_req_w || (hold_q == C_HOLD_LAST)) begin
            // A release by the owner takes precedence over the limit.
            if (state_q == ST_GRANT) begin
                timeout_d = owner_req_w;
            end
            if (found_w) begin
                state_d  = ST_GRANT;
                grant_d  = 10'b1 << win_w;
                select_d = win_w;
                valid_d  = 1'b1;
                ptr_d    = win_w;
                hold_d   = 8'd0;
            end else begin
                state_d = ST_IDLE;
                grant_d = 10'd0;
                valid_d = 1'b0;
            end
        end else begin
            hold_d = hold_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= 10'd0;
            select_q  <= 4'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            hold_q    <= 8'd0;
            ptr_q     <= 4'd9;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            select_q  <= select_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            ptr_q     <= ptr_d;
        end
    end

    assign grant_o   = grant_q;
    assign select_o  = select_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_select_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_select_arbiter
// Purpose  : Self-checking bench for mux_select_arbiter. Two instances
//            (MAX_HOLD=8 and MAX_HOLD=1) share the same request stimulus.
//            A reference model predicts each instance's outputs at every edge
//            and queues them; a monitor pops and compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_select_arbiter;

    typedef struct packed {
        logic [9:0] g;
        logic [3:0] s;
        logic       v;
        logic       t;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [9:0] req;

    logic [9:0] grant8,   grant1;
    logic [3:0] select8,  select1;
    logic       valid8,   valid1;
    logic       timeout8, timeout1;

    logic [7:0] d_arr [10];
    logic [7:0] x8, x1;

    int n_checks;
    int n_fail;

    exp_t q8[$];
    exp_t q1[$];

    // model state per instance: 0 -> MAX_HOLD=8, 1 -> MAX_HOLD=1
    int m_own  [2];
    int m_ptr  [2];
    int m_hold [2];
    int m_sel  [2];
    bit m_busy [2];

    mux_select_arbiter #(.MAX_HOLD(8)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req),
        .grant_o  (grant8),
        .select_o (select8),
        .valid_o  (valid8),
        .timeout_o(timeout8)
    );

    mux_select_arbiter #(.MAX_HOLD(1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req),
        .grant_o  (grant1),
        .select_o (select1),
        .valid_o  (valid1),
        .timeout_o(timeout1)
    );

    // the shared mux whose select the arbiter drives
    assign x8 = d_arr[select8];
    assign x1 = d_arr[select1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k]  = 0;
            m_ptr[k]  = 9;
            m_hold[k] = 0;
            m_sel[k]  = 0;
            m_busy[k] = 0;
        end
    endfunction

    // One clock edge of the arbitration rules, written from the behaviour
    // description: search order ptr+1..ptr+10 mod 10, first requester wins.
    function automatic exp_t model_step(int k, int limit, logic [9:0] r);
        exp_t e;
        bit   search;
        bit   to;
        int   idx;
        search = 1'b0;
        to     = 1'b0;
        if (!m_busy[k]) begin
            search = 1'b1;
        end else if (!r[m_own[k]]) begin
            search = 1'b1;
        end else if (m_hold[k] == limit - 1) begin
            search = 1'b1;
            to     = 1'b1;
        end else begin
            m_hold[k] = m_hold[k] + 1;
        end
        if (search) begin
            m_busy[k] = 1'b0;
            for (int j = 1; j <= 10; j++) begin
                idx = (m_ptr[k] + j) % 10;
                if (!m_busy[k] && r[idx]) begin
                    m_busy[k] = 1'b1;
                    m_own[k]  = idx;
                    m_ptr[k]  = idx;
                    m_sel[k]  = idx;
                    m_hold[k] = 0;
                end
            end
        end
        e.g = m_busy[k] ? (10'd1 << m_own[k]) : 10'd0;
        e.s = 4'(m_sel[k]);
        e.v = m_busy[k];
        e.t = to;
        return e;
    endfunction

    // reference model: predicts the outputs produced by each edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
            q8.delete();
            q1.delete();
        end else begin
            q8.push_back(model_step(0, 8, req));
            q1.push_back(model_step(1, 1, req));
        end
    end

    // monitor: compares every presented output against the queued prediction
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && q8.size() > 0) begin
            e = q8.pop_front();
            check("dut8 grant",   int'(grant8),   int'(e.g));
            check("dut8 select",  int'(select8),  int'(e.s));
            check("dut8 valid",   int'(valid8),   int'(e.v));
            check("dut8 timeout", int'(timeout8), int'(e.t));
            if (e.v) check("dut8 mux X", int'(x8), int'(d_arr[e.s]));
        end
        if (rst_n && q1.size() > 0) begin
            e = q1.pop_front();
            check("dut1 grant",   int'(grant1),   int'(e.g));
            check("dut1 select",  int'(select1),  int'(e.s));
            check("dut1 valid",   int'(valid1),   int'(e.v));
            check("dut1 timeout", int'(timeout1), int'(e.t));
            if (e.v) check("dut1 mux X", int'(x1), int'(d_arr[e.s]));
        end
    end

    // drive req right after a falling edge and hold it for n rising edges
    task automatic drive(input logic [9:0] v, input int n);
        req = v;
        repeat (n) @(negedge clk);
    endtask

    // asynchronous reset asserted between edges; outputs must clear at once
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("async grant8",   int'(grant8),   0);
        check("async select8",  int'(select8),  0);
        check("async valid8",   int'(valid8),   0);
        check("async timeout8", int'(timeout8), 0);
        check("async grant1",   int'(grant1),   0);
        check("async valid1",   int'(valid1),   0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [9:0] mask;
        n_checks = 0;
        n_fail   = 0;
        req      = 10'd0;
        rst_n    = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) d_arr[i] = 8'($urandom);
        #12;
        rst_n = 1'b1;
        @(negedge clk);

        // single requester 3, then release; select must hold 3 while idle
        drive(10'd0, 2);
        drive(10'h008, 4);
        drive(10'd0, 3);

        // all request: rotation with timeouts
        drive(10'h3FF, 90);
        drive(10'd0, 2);

        // sole requester 9: re-granted after every timeout
        drive(10'h200, 20);
        drive(10'd0, 2);

        // owner 2 drops exactly when the limit would be reached
        do_reset();
        drive(10'h004, 1);
        drive(10'h024, 7);
        drive(10'h020, 3);
        drive(10'd0, 2);

        // wrap-around priority from ptr=9 and the mux data path
        do_reset();
        drive(10'h101, 4);
        drive(10'h100, 4);
        drive(10'd0, 2);

        // reset in the middle of a grant, then everyone requests
        drive(10'h3FF, 3);
        do_reset();
        drive(10'h3FF, 12);

        // randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end
            if ($urandom_range(0, 3) == 0) begin
                mask = 10'($urandom);
                req  = 10'($urandom) & mask;
            end
            if ($urandom_range(0, 49) == 0) begin
                d_arr[$urandom_range(0, 9)] = 8'($urandom);
            end
            @(negedge clk);
        end
        req = 10'd0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
